// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
// Contents: default counter width, reset half-period, output mode enum.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_CNT_W   = 22;
  localparam int unsigned CLKDIV_DEF_DIV = 50;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clkdiv_mode_e;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active/shadow configuration, pending flag,
// registered outclk and tick.
// Optional feature macro: CLKDIV_SYNC_EN adds the sync phase-align input.
// Ports:
//   inclk, rst      clock, async active-low reset
//   en              channel run enable
//   sync            phase-align strobe (CLKDIV_SYNC_EN only)
//   wr              accepted configuration write for this channel
//   wr_div, wr_mode new half-period and mode for the shadow
//   outclk, tick    divided output and wrap strobe (registered)
//   pending         shadow holds a configuration not yet applied
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W   = CLKDIV_CNT_W,
  parameter int unsigned DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic             inclk,
  input  logic             rst,
  input  logic             en,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  clkdiv_mode_e     wr_mode,
  output logic             outclk,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic [CNT_W-1:0] hp_m1;
  clkdiv_mode_e     act_mode_q, act_mode_d;
  clkdiv_mode_e     sh_mode_q, sh_mode_d;
  logic             outclk_d, tick_d, pending_d;
  logic             wrap, apply, restart;

  // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
  assign hp_m1 = (act_div_q == '0) ? '0 : act_div_q - CNT_W'(1);
  assign wrap  = (count_q == hp_m1);

  // Disable and sync share one action: zero the phase and apply any shadow.
`ifdef CLKDIV_SYNC_EN
  assign restart = ~en | sync;
`else
  assign restart = ~en;
`endif

  // Next-state: restart beats wrap; the wrap action uses the old mode.
  always_comb begin
    count_d    = count_q;
    outclk_d   = outclk;
    tick_d     = 1'b0;
    apply      = 1'b0;
    if (restart) begin
      count_d  = '0;
      outclk_d = 1'b0;
      apply    = pending;
    end else if (wrap) begin
      count_d  = '0;
      tick_d   = 1'b1;
      outclk_d = (act_mode_q == MODE_PULSE) ? 1'b1 : ~outclk;
      apply    = pending;
    end else begin
      count_d  = count_q + CNT_W'(1);
      if (act_mode_q == MODE_PULSE) begin
        outclk_d = 1'b0;
      end
    end

    act_div_d  = apply ? sh_div_q  : act_div_q;
    act_mode_d = apply ? sh_mode_q : act_mode_q;
    sh_div_d   = wr ? wr_div  : sh_div_q;
    sh_mode_d  = wr ? wr_mode : sh_mode_q;
    // wr is only possible while pending is clear, so a write landing on a
    // wrap edge stays pending until the following wrap.
    pending_d  = wr | (pending & ~apply);
  end

  // State register.
  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      act_div_q  <= CNT_W'(DEF_DIV);
      act_mode_q <= MODE_TOGGLE;
      sh_div_q   <= CNT_W'(DEF_DIV);
      sh_mode_q  <= MODE_TOGGLE;
      pending    <= 1'b0;
      outclk     <= 1'b0;
      tick       <= 1'b0;
    end else begin
      count_q    <= count_d;
      act_div_q  <= act_div_d;
      act_mode_q <= act_mode_d;
      sh_div_q   <= sh_div_d;
      sh_mode_q  <= sh_mode_d;
      pending    <= pending_d;
      outclk     <= outclk_d;
      tick       <= tick_d;
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider / clock-enable generator.
// Optional feature macro: CLKDIV_SYNC_EN adds the sync input that restarts
// all enabled channels in phase.
// Ports:
//   inclk, rst          clock, async active-low reset
//   en[CHANNELS]        per-channel run enable
//   cfg_valid/cfg_ready configuration handshake (cfg_ready is combinational)
//   cfg_chan            target channel
//   cfg_div, cfg_mode   new half-period and mode (0 toggle, 1 pulse)
//   sync                phase-align strobe (CLKDIV_SYNC_EN only)
//   outclk, tick        divided outputs and wrap strobes (registered)
//   pending             per-channel shadow not yet applied
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = CLKDIV_CNT_W,
  parameter int unsigned DEF_DIV  = CLKDIV_DEF_DIV
) (
  input  logic                                         inclk,
  input  logic                                         rst,
  input  logic [CHANNELS-1:0]                          en,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] cfg_chan,
  input  logic [CNT_W-1:0]                             cfg_div,
  input  logic                                         cfg_mode,
`ifdef CLKDIV_SYNC_EN
  input  logic                                         sync,
`endif
  output logic [CHANNELS-1:0]                          outclk,
  output logic [CHANNELS-1:0]                          tick,
  output logic [CHANNELS-1:0]                          pending
);

  localparam int unsigned SEL_W = $clog2(CHANNELS > 1 ? CHANNELS : 2);

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] wr;

  // An out-of-range cfg_chan hits no channel, so cfg_ready stays low.
  assign cfg_ready = |(hit & ~pending);
  assign wr        = hit & {CHANNELS{cfg_valid & cfg_ready}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign hit[g] = (cfg_chan == SEL_W'(g));

    clkdiv_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .inclk   (inclk),
      .rst     (rst),
      .en      (en[g]),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync),
`endif
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .wr_mode (clkdiv_mode_e'(cfg_mode)),
      .outclk  (outclk[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Multi-channel programmable clock divider and clock-enable generator. It runs in the 100 MHz `inclk` domain and drives up to `CHANNELS` independent divided outputs for downstream timing logic. Each channel has a runtime-loadable half-period and a mode (50 % square wave or single-cycle pulse). Configuration updates are shadowed and applied glitch-free at the channel's next period boundary.

## Interface
- `CHANNELS`, 4: number of divider channels (1..16).
- `CNT_W`, 22: counter and divisor width.
- `DEF_DIV`, 50: reset half-period in `inclk` cycles (50 gives 1 MHz from 100 MHz).

- `inclk` in 1: the single clock.
- `rst` in 1: reset, asynchronous assert, active-low.
- `en` in CHANNELS: per-channel run enable.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: request can be accepted.
- `cfg_chan` in max($clog2(CHANNELS),1): target channel.
- `cfg_div` in CNT_W: new half-period.
- `cfg_mode` in 1: 0 = toggle (square), 1 = pulse.
- `sync` in 1: phase-align strobe (only with `CLKDIV_SYNC_EN`).
- `outclk` out CHANNELS: divided outputs, registered.
- `tick` out CHANNELS: one-cycle strobe at each channel wrap, registered.
- `pending` out CHANNELS: shadow configuration not yet applied.

## Operation
- Effective half-period: HP = max(div, 1). A value of 0 behaves as 1, i.e. divide-by-2.
- Enabled channel, ordinary edge: `count` increments, `tick` goes to 0, and `outclk` goes to 0 in pulse mode (held in toggle mode).
- Enabled channel, wrap edge (`count == HP-1`):
  - `count` goes to 0 and `tick` goes to 1.
  - `outclk` toggles in toggle mode and goes to 1 in pulse mode.
- Disabled channel (`en` low): `count`, `outclk` and `tick` are all 0. A pending shadow is applied immediately.
- Config handshake:
  - Transfer occurs when `cfg_valid & cfg_ready`.
  - `cfg_ready` is `~pending[cfg_chan]`, and is 0 if `cfg_chan >= CHANNELS`.
  - On transfer, `cfg_div` and `cfg_mode` are written to the channel's shadow and `pending` is set.
- Apply:
  - On a wrap edge with `pending` set, the active div and mode load from the shadow and `pending` clears.
  - The wrap action itself uses the old mode. The new HP counts from `count = 0`.
- Simultaneous transfer and wrap on the same channel: the shadow is written, `pending` is set, and the update applies at the following wrap, not this one.
- Reset values:
  - `outclk` = 0, `tick` = 0, `pending` = 0, `cfg_ready` = 1.
  - `count` = 0; active div = `DEF_DIV`; mode = toggle; shadows = `DEF_DIV`/toggle.
- Reset mid-period: all state returns to reset values immediately. No partial period is completed.
- Counter arithmetic is unsigned CNT_W. HP ≤ 2^CNT_W−1, so the counter never overflows.

## Timing
- With `en` high from reset release, the first `outclk` rise occurs on edge HP. The square period is 2·HP; the pulse period is HP with 1-cycle high.
- `tick` is coincident with the changed `outclk` value.
- `cfg_ready` combinationally follows `pending`. `pending` clears on the apply edge, so `cfg_ready` rises in the next cycle.
- Latency from transfer to new period: the remainder of the current half-period (up to HP cycles) when the channel is enabled, or 1 cycle when it is disabled.

## Configuration
- `CLKDIV_SYNC_EN` defined:
  - The `sync` port exists.
  - On an edge with `sync` high, every enabled channel sets `count`, `outclk` and `tick` to 0 and applies any pending shadow.
  - `sync` has priority over the wrap action. This aligns all channel phases.
- `CLKDIV_SYNC_EN` undefined: the `sync` port and its logic are absent, and channels run free relative to one another.

## Structure
- `clkdiv_pkg`:
  - `CNT_W` default.
  - Mode enum `clkdiv_mode_e` (`MODE_TOGGLE`, `MODE_PULSE`).
  - `DEF_DIV` constant.
- Sub-module `clkdiv_chan`:
  - One instance per channel, generated `CHANNELS` times.
  - Owns the counter, active and shadow registers, `pending`, `outclk` and `tick`.
- Top level: handshake decode, `cfg_chan` demux, and `sync` fan-out.

## Test plan
- Reset release with `en` = 4'b0001 and defaults → `outclk[0]` first rises on edge 50 with period 100; `tick[0]` pulses every 50 cycles; other channels stay 0.
- At count 20, load ch0 `cfg_div` = 3 → remaining 30 cycles at old HP; `pending[0]` stays high and `cfg_ready` is low for ch0; then the period is 6 cycles.
- Ch1 loaded with div = 4, mode = pulse, then enabled → `outclk[1]` is high 1 cycle in every 4, coincident with `tick[1]`.
- `cfg_div` = 0 and `cfg_div` = 1 → both give a divide-by-2 square wave; wrap at `count` = 0 each cycle.
- Assert `rst` low mid-period with `pending` set → all outputs 0 at once, `pending` clears, defaults resume with period 100.
- `CLKDIV_SYNC_EN`: ch0 at HP 5 and ch1 at HP 7 out of phase, pulse `sync` → both restart from count 0, first rises on edges 5 and 7 after `sync`.
